branch_resolve_bht: RTL and testbench

- Parametrised successor to the EXE-stage branch comparator.
- Resolves MIPS conditional branches in EXE with signed compares against zero.
- Keeps a PC-indexed table of saturating counters that supplies a taken prediction to IF.
- On a mispredict, issues a registered redirect with a valid/ready handshake and stalls EXE until IF accepts the redirect.

---
 rtl/branch_resolve_bht_pkg.sv | 58 +++++
 rtl/branch_resolve_bht_counter_table.sv | 65 ++++++
 rtl/branch_resolve_bht.sv | 175 +++++++++++++++++
 tb/tb_branch_resolve_bht.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_bht_pkg
// Shared CPU definitions for the EXE-stage branch resolver and its branch
// history table: the branch-type payload, the MIPS branch code enum, the
// table size defaults and the redirect FSM state enum.
// Helper functions: branch_taken (condition evaluation from compare flags)
// and branch_code_known (defined branch codes).
// ----------------------------------------------------------------------------
package branch_resolve_bht_pkg;

   localparam int unsigned BHT_DEPTH_DEF = 64;
   localparam int unsigned CTR_WIDTH_DEF = 2;
   localparam int unsigned BR_CODE_W     = 3;

   // Codes 6 and 7 are undefined: never taken and never train the table.
   typedef enum logic [BR_CODE_W-1:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BGEZ = 3'd2,
      BR_BGTZ = 3'd3,
      BR_BLEZ = 3'd4,
      BR_BLTZ = 3'd5
   } br_code_e;

   typedef struct packed {
      logic     is_branch;
      br_code_e code;
   } branch_type_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } redirect_state_e;

   // Branch outcome from the rs/rt compare flags; undefined codes resolve not-taken.
   function automatic logic branch_taken(input br_code_e code,
                                         input logic     a_eq_b,
                                         input logic     a_neg,
                                         input logic     a_zero);
      logic taken;
      taken = 1'b0;
      case (code)
         BR_BEQ:  taken = a_eq_b;
         BR_BNE:  taken = !a_eq_b;
         BR_BGEZ: taken = !a_neg;
         BR_BGTZ: taken = !a_neg && !a_zero;
         BR_BLEZ: taken = a_neg || a_zero;
         BR_BLTZ: taken = a_neg;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   function automatic logic branch_code_known(input br_code_e code);
      return (code <= BR_BLTZ);
   endfunction

endpackage

// File: rtl/branch_resolve_bht_counter_table.sv
// ----------------------------------------------------------------------------
// bht_counter_table
// PC-indexed table of saturating up/down counters.
//   clk, resetn      : clock, asynchronous active-low reset
//   rd_idx_i         : combinational lookup index
//   rd_ctr_o         : counter value at rd_idx_i (pre-update value this cycle)
//   we_i             : train the entry at wr_idx_i at the clock edge
//   wr_idx_i         : entry to train
//   wr_taken_i       : 1 = count up, 0 = count down (saturating both ends)
// Reset initialises every entry to weakly not-taken, 2^(CTR_W-1)-1.
// ----------------------------------------------------------------------------
module bht_counter_table
   import branch_resolve_bht_pkg::*;
#(
   parameter int unsigned DEPTH = BHT_DEPTH_DEF,
   parameter int unsigned CTR_W = CTR_WIDTH_DEF,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CTR_W-1:0] rd_ctr_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   localparam int unsigned INIT_VAL = (1 << (CTR_W - 1)) - 1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_VAL);
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

   logic [CTR_W-1:0] ctr_q [DEPTH];
   logic [CTR_W-1:0] wr_cur;
   logic [CTR_W-1:0] wr_nxt;

   // Read port: no write bypass, a same-cycle update is seen next cycle.
   assign rd_ctr_o = ctr_q[rd_idx_i];

   // Saturating next value for the entry being trained.
   always_comb begin
      wr_cur = ctr_q[wr_idx_i];
      wr_nxt = wr_cur;
      if (wr_taken_i) begin
         if (wr_cur != CTR_MAX) begin
            wr_nxt = wr_cur + CTR_W'(1);
         end
      end else begin
         if (wr_cur != '0) begin
            wr_nxt = wr_cur - CTR_W'(1);
         end
      end
   end

   // Counter storage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (we_i) begin
         ctr_q[wr_idx_i] <= wr_nxt;
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// branch_resolve_bht
// EXE-stage MIPS conditional branch resolver with a PC-indexed saturating
// counter branch history table. Mispredicts raise a registered redirect with
// a valid/ready handshake; EXE is stalled until IF accepts it.
//   clk, resetn          : clock, asynchronous active-low reset
//   if_pc                : fetch PC for the table lookup
//   if_pred_taken        : combinational prediction (counter MSB)
//   exe_valid            : EXE holds a valid instruction
//   exe_branch_type      : {is_branch, code}
//   exe_src_a/exe_src_b  : rs / rt operands
//   exe_pc, exe_target   : branch PC and taken target
//   exe_pred_taken       : prediction carried down the pipe
//   exe_stall_req        : high while a redirect is pending
//   redirect_valid/pc    : redirect request and corrected fetch PC
//   redirect_ready       : IF accepts the redirect
//   ifid_flush           : one-cycle flush pulse on mispredict
// Optional build macro BRANCH_STATS_EN adds stat_branches / stat_mispredicts
// (saturating 32-bit event counters).
// ----------------------------------------------------------------------------
module branch_resolve_bht
   import branch_resolve_bht_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned BHT_DEPTH  = BHT_DEPTH_DEF,
   parameter int unsigned CTR_WIDTH  = CTR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [PC_WIDTH-1:0]   if_pc,
   output logic                  if_pred_taken,
   input  logic                  exe_valid,
   input  branch_type_t          exe_branch_type,
   input  logic [DATA_WIDTH-1:0] exe_src_a,
   input  logic [DATA_WIDTH-1:0] exe_src_b,
   input  logic [PC_WIDTH-1:0]   exe_pc,
   input  logic [PC_WIDTH-1:0]   exe_target,
   input  logic                  exe_pred_taken,
   output logic                  exe_stall_req,
   output logic                  redirect_valid,
   output logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  redirect_ready,
   output logic                  ifid_flush
`ifdef BRANCH_STATS_EN
   ,output logic [31:0]          stat_branches
   ,output logic [31:0]          stat_mispredicts
`endif
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0]     if_idx;
   logic [IDX_W-1:0]     exe_idx;
   logic [CTR_WIDTH-1:0] if_ctr;
   logic                 a_eq_b;
   logic                 a_neg;
   logic                 a_zero;
   logic                 res_c;
   logic                 taken_c;
   logic                 upd_c;
   logic                 mispredict_c;

   redirect_state_e      state_q, state_d;
   logic                 redirect_valid_q, redirect_valid_d;
   logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
   logic                 ifid_flush_q, ifid_flush_d;

   // Word-aligned table index; low two PC bits and upper bits do not index.
   assign if_idx  = if_pc[IDX_W+1:2];
   assign exe_idx = exe_pc[IDX_W+1:2];

   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], if_pc[PC_WIDTH-1:IDX_W+2], if_ctr};

   // Signed compares against zero only need the sign bit and a zero detect.
   assign a_eq_b = (exe_src_a == exe_src_b);
   assign a_neg  = exe_src_a[DATA_WIDTH-1];
   assign a_zero = (exe_src_a == '0);

   // Branches in EXE are only resolved while no redirect is outstanding.
   assign res_c        = exe_valid && exe_branch_type.is_branch && (state_q == ST_IDLE);
   assign taken_c      = branch_taken(exe_branch_type.code, a_eq_b, a_neg, a_zero);
   assign upd_c        = res_c && branch_code_known(exe_branch_type.code);
   assign mispredict_c = res_c && (taken_c != exe_pred_taken);

   bht_counter_table #(
      .DEPTH (BHT_DEPTH),
      .CTR_W (CTR_WIDTH)
   ) u_table (
      .clk        (clk),
      .resetn     (resetn),
      .rd_idx_i   (if_idx),
      .rd_ctr_o   (if_ctr),
      .we_i       (upd_c),
      .wr_idx_i   (exe_idx),
      .wr_taken_i (taken_c)
   );

   assign if_pred_taken = if_ctr[CTR_WIDTH-1];

   // Redirect FSM: next state and redirect register values.
   always_comb begin
      state_d          = state_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      ifid_flush_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mispredict_c) begin
               state_d          = ST_REDIRECT;
               redirect_valid_d = 1'b1;
               ifid_flush_d     = 1'b1;
               // Not-taken resumes after the delay slot.
               redirect_pc_d    = taken_c ? exe_target : (exe_pc + PC_WIDTH'(8));
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               state_d          = ST_IDLE;
               redirect_valid_d = 1'b0;
            end
         end
         default: begin
            state_d          = ST_IDLE;
            redirect_valid_d = 1'b0;
         end
      endcase
   end

   // Redirect FSM state and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         ifid_flush_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         ifid_flush_q     <= ifid_flush_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign ifid_flush     = ifid_flush_q;
   // Decoded straight from the state register, never from EXE inputs.
   assign exe_stall_req  = (state_q == ST_REDIRECT);

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_mispredicts_q;

   // Saturating resolve / mispredict event counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         if (res_c && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_q <= stat_branches_q + 32'd1;
         end
         if (mispredict_c && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
         end
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_bht
// Directed bench for branch_resolve_bht: a vector table of single branches
// with hand-computed redirect results, plus sequences for reset, table
// training, handshake stall and counter saturation.
// ----------------------------------------------------------------------------
module tb_branch_resolve_bht;
   import branch_resolve_bht_pkg::*;

   logic         clk;
   logic         resetn;
   logic [31:0]  if_pc;
   logic         if_pred_taken;
   logic         exe_valid;
   branch_type_t exe_branch_type;
   logic [31:0]  exe_src_a;
   logic [31:0]  exe_src_b;
   logic [31:0]  exe_pc;
   logic [31:0]  exe_target;
   logic         exe_pred_taken;
   logic         exe_stall_req;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         redirect_ready;
   logic         ifid_flush;
`ifdef BRANCH_STATS_EN
   logic [31:0]  stat_branches;
   logic [31:0]  stat_mispredicts;
`endif

   int n_cmp;
   int n_err;

   branch_resolve_bht dut (
      .clk             (clk),
      .resetn          (resetn),
      .if_pc           (if_pc),
      .if_pred_taken   (if_pred_taken),
      .exe_valid       (exe_valid),
      .exe_branch_type (exe_branch_type),
      .exe_src_a       (exe_src_a),
      .exe_src_b       (exe_src_b),
      .exe_pc          (exe_pc),
      .exe_target      (exe_target),
      .exe_pred_taken  (exe_pred_taken),
      .exe_stall_req   (exe_stall_req),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .redirect_ready  (redirect_ready),
      .ifid_flush      (ifid_flush)
`ifdef BRANCH_STATS_EN
      ,.stat_branches    (stat_branches)
      ,.stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_br;
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pred;
      logic        exp_redir;
      logic [31:0] exp_rpc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_br(input logic is_br, input logic [2:0] code,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pred);
      exe_valid                 = 1'b1;
      exe_branch_type.is_branch = is_br;
      exe_branch_type.code      = br_code_e'(code);
      exe_src_a                 = a;
      exe_src_b                 = b;
      exe_pc                    = pc;
      exe_target                = tgt;
      exe_pred_taken            = pred;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn         = 1'b0;
      exe_valid      = 1'b0;
      redirect_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      resetn = 1'b0;
      if_pc = 32'h0040_0000;
      exe_valid = 1'b0;
      exe_branch_type = '0;
      exe_src_a = '0;
      exe_src_b = '0;
      exe_pc = '0;
      exe_target = '0;
      exe_pred_taken = 1'b0;
      redirect_ready = 1'b0;

      // {is_br, code, a, b, pc, target, pred, exp_redirect, exp_redirect_pc}
      vecs.push_back('{1'b1, 3'd0, 32'h5, 32'h5, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b1, 32'h0040_0100});
      vecs.push_back('{1'b1, 3'd1, 32'h1, 32'h2, 32'h0040_0014, 32'h0040_0200, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd1, 32'h7, 32'h7, 32'h0040_0018, 32'h0040_0300, 1'b1, 1'b1, 32'h0040_0020});
      vecs.push_back('{1'b1, 3'd2, 32'h0, 32'h9, 32'h0040_0030, 32'h0040_0400, 1'b0, 1'b1, 32'h0040_0400});
      vecs.push_back('{1'b1, 3'd2, 32'h8000_0000, 32'h0, 32'h0040_0040, 32'h0040_0410, 1'b1, 1'b1, 32'h0040_0048});
      vecs.push_back('{1'b1, 3'd3, 32'h0, 32'h0, 32'h0040_0020, 32'h0040_0420, 1'b1, 1'b1, 32'h0040_0028});
      vecs.push_back('{1'b1, 3'd3, 32'h7FFF_FFFF, 32'h0, 32'h0040_0024, 32'h0040_0430, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd4, 32'h0, 32'h0, 32'h0040_0028, 32'h0040_0440, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd4, 32'h1, 32'h0, 32'h0040_002C, 32'h0040_0450, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0040_0050, 32'h0040_0500, 1'b0, 1'b1, 32'h0040_0500});
      vecs.push_back('{1'b1, 3'd5, 32'h0, 32'h0, 32'h0040_0054, 32'h0040_0510, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd4, 32'h8000_0000, 32'h0, 32'h0040_0060, 32'h0040_0600, 1'b0, 1'b1, 32'h0040_0600});
      vecs.push_back('{1'b1, 3'd7, 32'h5, 32'h5, 32'h0040_0064, 32'h0040_0610, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd6, 32'h5, 32'h5, 32'h0040_0070, 32'h0040_0620, 1'b1, 1'b1, 32'h0040_0078});
      vecs.push_back('{1'b1, 3'd0, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h0040_0630, 1'b1, 1'b1, 32'h0000_0004});
      vecs.push_back('{1'b0, 3'd0, 32'h5, 32'h5, 32'h0040_0074, 32'h0040_0640, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 3'd3, 32'h8000_0000, 32'h0, 32'h0040_0080, 32'h0040_0650, 1'b1, 1'b1, 32'h0040_0088});

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_flush", 32'(ifid_flush), 32'd0);
      check("rst_stall", 32'(exe_stall_req), 32'd0);
      check("rst_pred", 32'(if_pred_taken), 32'd0);
`ifdef BRANCH_STATS_EN
      check("rst_stat_branches", stat_branches, 32'd0);
      check("rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
      resetn = 1'b1;

      // Vector table; ready held high, which is ignored while IDLE.
      redirect_ready = 1'b1;
      foreach (vecs[i]) begin
         drive_br(vecs[i].is_br, vecs[i].code, vecs[i].a, vecs[i].b,
                  vecs[i].pc, vecs[i].tgt, vecs[i].pred);
         tick();
         exe_valid = 1'b0;
         check($sformatf("vec%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_redir));
         check($sformatf("vec%0d_flush", i), 32'(ifid_flush), 32'(vecs[i].exp_redir));
         check($sformatf("vec%0d_stall", i), 32'(exe_stall_req), 32'(vecs[i].exp_redir));
         if (vecs[i].exp_redir) begin
            check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
         end
         tick();
         check($sformatf("vec%0d_idle_valid", i), 32'(redirect_valid), 32'd0);
         check($sformatf("vec%0d_idle_flush", i), 32'(ifid_flush), 32'd0);
         check($sformatf("vec%0d_idle_stall", i), 32'(exe_stall_req), 32'd0);
      end

      // BLTZ with a negative operand, correctly predicted: trains 01 -> 10.
      do_reset();
      if_pc = 32'h0040_0040;
      drive_br(1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0040_0040, 32'h0040_0700, 1'b1);
      #1;
      check("bltz_same_cycle_pred", 32'(if_pred_taken), 32'd0);
      @(negedge clk);
      exe_valid = 1'b0;
      check("bltz_no_redirect", 32'(redirect_valid), 32'd0);
      check("bltz_no_stall", 32'(exe_stall_req), 32'd0);
      check("bltz_pred_after", 32'(if_pred_taken), 32'd1);

      // Handshake stall: redirect held for 3 cycles, EXE branch ignored meanwhile.
      do_reset();
      if_pc = 32'h0040_0084;
      drive_br(1'b1, 3'd1, 32'h1, 32'h2, 32'h0040_0080, 32'h0040_0200, 1'b0);
      tick();
      drive_br(1'b1, 3'd0, 32'h5, 32'h5, 32'h0040_0084, 32'h0040_0900, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hs%0d_valid", k), 32'(redirect_valid), 32'd1);
         check($sformatf("hs%0d_pc", k), redirect_pc, 32'h0040_0200);
         check($sformatf("hs%0d_stall", k), 32'(exe_stall_req), 32'd1);
         check($sformatf("hs%0d_flush", k), 32'(ifid_flush), (k == 0) ? 32'd1 : 32'd0);
         tick();
      end
      check("hs_ignored_branch_ctr", 32'(if_pred_taken), 32'd0);
      redirect_ready = 1'b1;
      exe_valid = 1'b0;
      tick();
      check("hs_release_valid", 32'(redirect_valid), 32'd0);
      check("hs_release_stall", 32'(exe_stall_req), 32'd0);
      if_pc = 32'h0040_0080;
      #1;
      check("hs_trained_ctr", 32'(if_pred_taken), 32'd1);

      // Saturation: 4 taken then 4 not-taken at one index, no mispredicts.
      do_reset();
      if_pc = 32'h0040_0030;
      for (int k = 0; k < 8; k++) begin
         logic [31:0] sb;
         logic        exp_pred;
         sb = (k < 4) ? 32'h5 : 32'h6;
         drive_br(1'b1, 3'd0, 32'h5, sb, 32'h0040_0030, 32'h0040_0800, (k < 4));
         tick();
         // 01 -> 10,11,11,11 -> 10,01,00,00
         exp_pred = (k < 5);
         check($sformatf("sat%0d_pred", k), 32'(if_pred_taken), 32'(exp_pred));
         check($sformatf("sat%0d_no_redirect", k), 32'(redirect_valid), 32'd0);
      end
      exe_valid = 1'b0;
`ifdef BRANCH_STATS_EN
      check("sat_stat_branches", stat_branches, 32'd8);
      check("sat_stat_mispredicts", stat_mispredicts, 32'd0);
`endif

      // Async reset mid-redirect clears FSM and counters.
      do_reset();
      if_pc = 32'h0040_0000;
      drive_br(1'b1, 3'd0, 32'h5, 32'h5, 32'h0040_0000, 32'h0040_0100, 1'b1);
      tick();
      tick();
      check("mid_trained_pred", 32'(if_pred_taken), 32'd1);
      drive_br(1'b1, 3'd0, 32'h5, 32'h5, 32'h0040_0000, 32'h0040_0100, 1'b0);
      tick();
      exe_valid = 1'b0;
      check("mid_redirect_valid", 32'(redirect_valid), 32'd1);
`ifdef BRANCH_STATS_EN
      check("mid_stat_branches", stat_branches, 32'd3);
      check("mid_stat_mispredicts", stat_mispredicts, 32'd1);
`endif
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(redirect_valid), 32'd0);
      check("mid_rst_pc", redirect_pc, 32'd0);
      check("mid_rst_flush", 32'(ifid_flush), 32'd0);
      check("mid_rst_stall", 32'(exe_stall_req), 32'd0);
      check("mid_rst_pred", 32'(if_pred_taken), 32'd0);
`ifdef BRANCH_STATS_EN
      check("mid_rst_stat_branches", stat_branches, 32'd0);
`endif
      @(negedge clk);
      resetn = 1'b1;
      tick();
      check("mid_dropped_valid", 32'(redirect_valid), 32'd0);
      check("mid_dropped_stall", 32'(exe_stall_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
